// File: rtl/issue_queue_dpi.sv
// Issue queue in front of the DPI functional unit.
// One source operand per entry, tag wakeup from the writeback bus, and
// fixed lowest-index selection. Issued fields are registered onto the
// outputs that feed the DPI unit.
module issue_queue_dpi #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [31:0]                  disp_inst,
  input  logic [63:0]                  disp_pc,
  input  logic [PRN_W-1:0]             disp_src_prn,
  input  logic                         disp_src_rdy,
  input  logic [63:0]                  disp_src_data,
  input  logic [PRN_W-1:0]             disp_dst_prn,
  input  logic [ID_W-1:0]              disp_inst_id,
  input  logic                         wb_valid,
  input  logic [PRN_W-1:0]             wb_prn,
  input  logic [63:0]                  wb_data,
  input  logic                         flush,
  input  logic                         fu_ready,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [63:0]                  pc,
  output logic [63:0]                  op0,
  output logic [PRN_W-1:0]             out_prn,
  output logic [ID_W-1:0]              inst_id,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  // Entry storage
  logic             valid_reg    [DEPTH];
  logic [31:0]      inst_reg     [DEPTH];
  logic [63:0]      pc_reg       [DEPTH];
  logic [PRN_W-1:0] src_prn_reg  [DEPTH];
  logic             src_rdy_reg  [DEPTH];
  logic [63:0]      src_data_reg [DEPTH];
  logic [PRN_W-1:0] dst_prn_reg  [DEPTH];
  logic [ID_W-1:0]  inst_id_reg  [DEPTH];

  logic [CNT_W-1:0] count_reg;
  logic             inst_valid_reg;
  logic [31:0]      inst_out_reg;
  logic [63:0]      pc_out_reg;
  logic [63:0]      op0_out_reg;
  logic [PRN_W-1:0] prn_out_reg;
  logic [ID_W-1:0]  id_out_reg;

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] free_vec;
  logic             iss_any;
  logic [IDX_W-1:0] iss_idx;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             do_issue;
  logic             do_disp;
  logic             disp_bypass;

  // Eligibility and freeness come only from registered state, so anything
  // written on this edge waits at least one cycle before it can issue.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flags
      assign eligible[gi] = valid_reg[gi] & src_rdy_reg[gi];
      assign free_vec[gi] = ~valid_reg[gi];
    end
  endgenerate

  // Lowest-index eligible entry (issue select) and lowest-index free entry
  always_comb begin
    iss_any  = 1'b0;
    iss_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        iss_any = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (free_vec[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready  = (count_reg < CNT_W'(DEPTH));
  assign do_disp     = disp_valid & disp_ready & free_any & ~flush;
  assign do_issue    = fu_ready & iss_any & ~flush;
  assign disp_bypass = ~disp_src_rdy & wb_valid & (wb_prn == disp_src_prn);

  // Per-entry update: flush clears, issue frees, dispatch loads, wakeup captures
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi]    <= 1'b0;
          inst_reg[gi]     <= '0;
          pc_reg[gi]       <= '0;
          src_prn_reg[gi]  <= '0;
          src_rdy_reg[gi]  <= 1'b0;
          src_data_reg[gi] <= '0;
          dst_prn_reg[gi]  <= '0;
          inst_id_reg[gi]  <= '0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else begin
          // An issued entry is valid, so it can never also be the free slot.
          if (do_issue && iss_idx == IDX_W'(gi)) begin
            valid_reg[gi] <= 1'b0;
          end
          if (do_disp && free_idx == IDX_W'(gi)) begin
            valid_reg[gi]    <= 1'b1;
            inst_reg[gi]     <= disp_inst;
            pc_reg[gi]       <= disp_pc;
            src_prn_reg[gi]  <= disp_src_prn;
            src_rdy_reg[gi]  <= disp_src_rdy | disp_bypass;
            src_data_reg[gi] <= disp_bypass ? wb_data : disp_src_data;
            dst_prn_reg[gi]  <= disp_dst_prn;
            inst_id_reg[gi]  <= disp_inst_id;
          end else if (valid_reg[gi] && !src_rdy_reg[gi] && wb_valid &&
                       src_prn_reg[gi] == wb_prn) begin
            src_rdy_reg[gi]  <= 1'b1;
            src_data_reg[gi] <= wb_data;
          end
        end
      end
    end
  endgenerate

  // Occupancy counter: +1 on dispatch, -1 on issue, cleared by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (do_disp && !do_issue) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (do_issue && !do_disp) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Issue output register: payload holds between issues, valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid_reg <= 1'b0;
      inst_out_reg   <= '0;
      pc_out_reg     <= '0;
      op0_out_reg    <= '0;
      prn_out_reg    <= '0;
      id_out_reg     <= '0;
    end else begin
      inst_valid_reg <= do_issue;
      if (do_issue) begin
        inst_out_reg <= inst_reg[iss_idx];
        pc_out_reg   <= pc_reg[iss_idx];
        op0_out_reg  <= src_data_reg[iss_idx];
        prn_out_reg  <= dst_prn_reg[iss_idx];
        id_out_reg   <= inst_id_reg[iss_idx];
      end
    end
  end

  assign inst_valid = inst_valid_reg;
  assign inst       = inst_out_reg;
  assign pc         = pc_out_reg;
  assign op0        = op0_out_reg;
  assign out_prn    = prn_out_reg;
  assign inst_id    = id_out_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_issue_queue_dpi.sv
// Bench for issue_queue_dpi: directed vector table, reset sequence,
// then randomized traffic against a behavioural queue model.
module tb_issue_queue_dpi;

  localparam int DEPTH = 4;
  localparam int PRN_W = 7;
  localparam int ID_W  = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             disp_valid;
  logic             disp_ready;
  logic [31:0]      disp_inst;
  logic [63:0]      disp_pc;
  logic [PRN_W-1:0] disp_src_prn;
  logic             disp_src_rdy;
  logic [63:0]      disp_src_data;
  logic [PRN_W-1:0] disp_dst_prn;
  logic [ID_W-1:0]  disp_inst_id;
  logic             wb_valid;
  logic [PRN_W-1:0] wb_prn;
  logic [63:0]      wb_data;
  logic             flush;
  logic             fu_ready;
  logic             inst_valid;
  logic [31:0]      inst;
  logic [63:0]      pc;
  logic [63:0]      op0;
  logic [PRN_W-1:0] out_prn;
  logic [ID_W-1:0]  inst_id;
  logic [CW-1:0]    count;

  issue_queue_dpi #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_pc(disp_pc),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy),
    .disp_src_data(disp_src_data), .disp_dst_prn(disp_dst_prn),
    .disp_inst_id(disp_inst_id),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data(wb_data),
    .flush(flush), .fu_ready(fu_ready),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .op0(op0),
    .out_prn(out_prn), .inst_id(inst_id), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        dv;
    bit [6:0]  sprn;
    bit        srdy;
    bit [63:0] sdata;
    bit [6:0]  dprn;
    bit [4:0]  id;
    bit        wv;
    bit [6:0]  wprn;
    bit [63:0] wdata;
    bit        fu;
    bit        fl;
    int        e_cnt;
    bit        e_rdy;
    bit        e_iv;
    bit [63:0] e_op0;
    bit [6:0]  e_prn;
    bit [4:0]  e_id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit dv, input bit [6:0] sprn, input bit srdy, input bit [63:0] sdata,
                     input bit [6:0] dprn, input bit [4:0] id,
                     input bit wv, input bit [6:0] wprn, input bit [63:0] wdata,
                     input bit fu, input bit fl,
                     input int e_cnt, input bit e_rdy, input bit e_iv,
                     input bit [63:0] e_op0, input bit [6:0] e_prn, input bit [4:0] e_id);
    vec_t v;
    v.dv = dv; v.sprn = sprn; v.srdy = srdy; v.sdata = sdata; v.dprn = dprn; v.id = id;
    v.wv = wv; v.wprn = wprn; v.wdata = wdata; v.fu = fu; v.fl = fl;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_op0 = e_op0; v.e_prn = e_prn; v.e_id = e_id;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    disp_valid = 0; disp_inst = 0; disp_pc = 0; disp_src_prn = 0; disp_src_rdy = 0;
    disp_src_data = 0; disp_dst_prn = 0; disp_inst_id = 0;
    wb_valid = 0; wb_prn = 0; wb_data = 0; flush = 0; fu_ready = 0;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit [31:0] inst;
    bit [63:0] pc;
    bit [6:0]  sprn;
    bit        r;
    bit [63:0] d;
    bit [6:0]  dp;
    bit [4:0]  id;
  } ent_t;

  ent_t      m[DEPTH];
  bit        m_iv;
  bit [31:0] m_inst;
  bit [63:0] m_pc, m_op0;
  bit [6:0]  m_prn;
  bit [4:0]  m_id;

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m[k].v = 0;
    m_iv = 0; m_inst = 0; m_pc = 0; m_op0 = 0; m_prn = 0; m_id = 0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) if (m[k].v) c++;
    return c;
  endfunction

  // Apply one rising edge to the model using the currently driven inputs
  task automatic model_step();
    int iss = -1;
    int fr  = -1;
    int cnt;
    cnt = model_count();
    for (int k = 0; k < DEPTH; k++) begin
      if (iss < 0 && m[k].v && m[k].r) iss = k;
      if (fr < 0 && !m[k].v) fr = k;
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) m[k].v = 0;
      m_iv = 0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if (m[k].v && !m[k].r && wb_valid && m[k].sprn == wb_prn) begin
          m[k].r = 1; m[k].d = wb_data;
        end
      if (fu_ready && iss >= 0) begin
        m_iv = 1; m_inst = m[iss].inst; m_pc = m[iss].pc; m_op0 = m[iss].d;
        m_prn = m[iss].dp; m_id = m[iss].id; m[iss].v = 0;
      end else begin
        m_iv = 0;
      end
      if (disp_valid && cnt < DEPTH) begin
        m[fr].v = 1; m[fr].inst = disp_inst; m[fr].pc = disp_pc; m[fr].sprn = disp_src_prn;
        m[fr].dp = disp_dst_prn; m[fr].id = disp_inst_id;
        if (disp_src_rdy) begin
          m[fr].r = 1; m[fr].d = disp_src_data;
        end else if (wb_valid && wb_prn == disp_src_prn) begin
          m[fr].r = 1; m[fr].d = wb_data;
        end else begin
          m[fr].r = 0; m[fr].d = disp_src_data;
        end
      end
    end
  endtask

  initial begin
    // Table: dispatch, bypass, wakeup, full/drop, flush, issue+dispatch
    add(1, 0, 1, 64'h1234, 5, 3, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h1234, 5, 3);
    add(1, 9, 0, 0, 6, 4, 1, 9, 64'h77, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 64'h77, 6, 4);
    add(1, 9, 0, 0, 7, 5, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 9, 64'hABCD, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 64'hABCD, 7, 5);
    for (int i = 0; i < 4; i++)
      add(1, 0, 1, 64'h100 + i, 7'(10 + i), 5'(10 + i), 0, 0, 0, 0, 0, i + 1, (i < 3), 0, 0, 0, 0);
    add(1, 0, 1, 64'h999, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3 - i, 1, 1, 64'h100 + i, 7'(10 + i), 5'(10 + i));
    for (int i = 0; i < 3; i++)
      add(1, 20, 0, 0, 1, 1, 0, 0, 0, 0, 0, i + 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 20, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 64'hA1, 2, 2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 64'hA2, 3, 3, 0, 0, 0, 1, 0, 1, 1, 1, 64'hA1, 2, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 64'hA2, 3, 3);

    // Reset state
    idle_inputs();
    rst = 1;
    #12;
    chk("reset_count", count, 0);
    chk("reset_disp_ready", disp_ready, 1);
    chk("reset_inst_valid", inst_valid, 0);
    chk("reset_op0", op0, 0);
    chk("reset_inst_id", inst_id, 0);
    rst = 0;

    // Directed table, one edge per row
    for (int i = 0; i < vecs.size(); i++) begin
      disp_valid = vecs[i].dv; disp_src_prn = vecs[i].sprn; disp_src_rdy = vecs[i].srdy;
      disp_src_data = vecs[i].sdata; disp_dst_prn = vecs[i].dprn; disp_inst_id = vecs[i].id;
      disp_inst = 32'(i); disp_pc = 64'(i * 4);
      wb_valid = vecs[i].wv; wb_prn = vecs[i].wprn; wb_data = vecs[i].wdata;
      fu_ready = vecs[i].fu; flush = vecs[i].fl;
      @(posedge clk); #1;
      $display("row %0d: count=%0d ready=%0d iv=%0d op0=%0h prn=%0d id=%0d",
               i, count, disp_ready, inst_valid, op0, out_prn, inst_id);
      chk($sformatf("row%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("row%0d_ready", i), disp_ready, vecs[i].e_rdy);
      chk($sformatf("row%0d_iv", i), inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        chk($sformatf("row%0d_op0", i), op0, vecs[i].e_op0);
        chk($sformatf("row%0d_prn", i), out_prn, vecs[i].e_prn);
        chk($sformatf("row%0d_id", i), inst_id, vecs[i].e_id);
      end
    end

    // Asynchronous reset mid-cycle with count=2 and an issue on the outputs
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1; disp_src_rdy = 1; disp_src_data = 64'h500 + i; disp_inst_id = 5'(i + 1);
      @(posedge clk); #1;
    end
    idle_inputs();
    fu_ready = 1;
    @(posedge clk); #1;
    $display("pre-reset: count=%0d iv=%0d op0=%0h", count, inst_valid, op0);
    chk("prerst_count", count, 2);
    chk("prerst_iv", inst_valid, 1);
    chk("prerst_op0", op0, 64'h500);
    #2 rst = 1;
    #1;
    $display("async reset: count=%0d iv=%0d op0=%0h", count, inst_valid, op0);
    chk("arst_count", count, 0);
    chk("arst_iv", inst_valid, 0);
    chk("arst_op0", op0, 0);
    chk("arst_inst", inst, 0);
    chk("arst_pc", pc, 0);
    chk("arst_prn", out_prn, 0);
    chk("arst_id", inst_id, 0);
    chk("arst_ready", disp_ready, 1);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    model_reset();
    // First edge after reset accepts a dispatch
    disp_valid = 1; disp_src_rdy = 1; disp_src_data = 64'h42;
    model_step();
    @(posedge clk); #1;
    chk("postrst_count", count, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      disp_valid    = ($urandom_range(0, 99) < 60);
      disp_inst     = $urandom;
      disp_pc       = {$urandom, $urandom};
      disp_src_prn  = 7'($urandom_range(0, 7));
      disp_src_rdy  = ($urandom_range(0, 1) == 1);
      disp_src_data = {$urandom, $urandom};
      disp_dst_prn  = 7'($urandom);
      disp_inst_id  = 5'($urandom);
      wb_valid      = ($urandom_range(0, 99) < 40);
      wb_prn        = 7'($urandom_range(0, 7));
      wb_data       = {$urandom, $urandom};
      fu_ready      = ($urandom_range(0, 99) < 60);
      flush         = ($urandom_range(0, 99) < 4);
      model_step();
      @(posedge clk); #1;
      if (c % 100 == 0)
        $display("rand %0d: count=%0d iv=%0d op0=%0h", c, count, inst_valid, op0);
      chk("rand_count", count, model_count());
      chk("rand_ready", disp_ready, model_count() < DEPTH);
      chk("rand_iv", inst_valid, m_iv);
      chk("rand_inst", inst, m_inst);
      chk("rand_pc", pc, m_pc);
      chk("rand_op0", op0, m_op0);
      chk("rand_prn", out_prn, m_prn);
      chk("rand_id", inst_id, m_id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
